// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop controller in front of a single-port synchronous stack RAM.
// Owns the stack pointer, turns push/pop requests into RAM cycles, captures
// popped data and keeps full/empty/overflow/underflow status for the core.
//
// Request semantics: push, pop and flush are level requests sampled only while
// busy is low (state IDLE). At most one is actioned per cycle with priority
// flush > push > pop; lower-priority requests in the same cycle are dropped
// without side effects. While busy is high every request is ignored and nothing
// is queued. A pop completes when dout_valid pulses for one cycle with the word
// on dout.
module stack_ctrl #(
   parameter int WIDTH = 8,
   parameter int SIZE  = 32,
   parameter int AW    = $clog2(SIZE)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow,
   output logic [AW:0]      count,
   output logic [AW-1:0]    mem_address,
   output logic [WIDTH-1:0] mem_data,
   output logic             mem_wren,
   input  logic [WIDTH-1:0] mem_q,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_READ    = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(SIZE);

   state_t      state;
   state_t      next_state;
   logic        do_flush;
   logic        do_push;
   logic        do_pop;
   logic [AW:0] count_dec;

   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;
   assign count_dec = count - 1'b1;

   // Decode which single request (if any) is actioned this cycle.
   always_comb begin
      do_flush = 1'b0;
      do_push  = 1'b0;
      do_pop   = 1'b0;
      if (state == S_IDLE) begin
         if (flush)     do_flush = 1'b1;
         else if (push) do_push  = 1'b1;
         else if (pop)  do_pop   = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Next-state logic: rejected push/pop (full/empty) stays in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (do_push && !full)      next_state = S_WRITE;
            else if (do_pop && !empty) next_state = S_READ;
         end
         S_WRITE:   next_state = S_IDLE;
         S_READ:    next_state = S_CAPTURE;
         S_CAPTURE: next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // Stack pointer, sticky flags, RAM interface and pop result registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count       <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         mem_address <= '0;
         mem_data    <= '0;
         mem_wren    <= 1'b0;
         dout        <= '0;
         dout_valid  <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (do_flush) begin
                  count     <= '0;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
               end else if (do_push) begin
                  if (full) begin
                     overflow <= 1'b1;
                  end else begin
                     mem_address <= count[AW-1:0];
                     mem_data    <= din;
                     mem_wren    <= 1'b1;
                     count       <= count + 1'b1;
                  end
               end else if (do_pop) begin
                  if (empty) begin
                     underflow <= 1'b1;
                  end else begin
                     // Top entry lives at count-1; the RAM registers it next edge.
                     mem_address <= count_dec[AW-1:0];
                     count       <= count_dec;
                  end
               end
            end
            S_WRITE: mem_wren <= 1'b0;
            S_READ: ;
            S_CAPTURE: begin
               dout       <= mem_q;
               dout_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: randomized and directed checks of stack_ctrl against a
// queue-based stack model, with a behavioural synchronous RAM attached.
`timescale 1ns/1ps
module tb_stack_ctrl;

   localparam int WIDTH = 8;
   localparam int SIZE  = 32;
   localparam int AW    = 5;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic             flush = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             busy;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;
   logic [AW:0]      count;
   logic [AW-1:0]    mem_address;
   logic [WIDTH-1:0] mem_data;
   logic             mem_wren;
   logic [WIDTH-1:0] mem_q;
   logic [1:0]       state_dbg;

   int total = 0;
   int bad   = 0;

   // Reference model: the stack as a queue plus sticky flags.
   logic [WIDTH-1:0] stk_q[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;
   logic [WIDTH-1:0] m_dout = '0;

   // Behavioural single-port RAM with registered read address.
   logic [WIDTH-1:0] ram [SIZE];
   logic [AW-1:0]    ram_addr_r = '0;

   always @(posedge clock) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      ram_addr_r <= mem_address;
   end
   assign mem_q = ram[ram_addr_r];

   always #5 clock = ~clock;

   stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clock(clock), .reset_n(reset_n), .push(push), .pop(pop), .flush(flush),
      .din(din), .dout(dout), .dout_valid(dout_valid), .busy(busy), .full(full),
      .empty(empty), .overflow(overflow), .underflow(underflow), .count(count),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
      .mem_q(mem_q), .state_dbg(state_dbg)
   );

   // Drive one request for one cycle and check the full response against the model.
   task automatic op_req(input logic f, input logic p, input logic q, input logic [WIDTH-1:0] d);
      int n;
      int cyc;
      logic [WIDTH-1:0] exp_d;
      n = stk_q.size();
      flush = f; push = p; pop = q; din = d;
      @(posedge clock); #1;
      flush = 1'b0; push = 1'b0; pop = 1'b0;
      if (f) begin
         stk_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
         total++;
         if (count !== 6'd0 || overflow !== 1'b0 || underflow !== 1'b0 || busy !== 1'b0 || mem_wren !== 1'b0) begin
            bad++;
            $display("FAIL flush: count=%0d ovf=%b unf=%b busy=%b wren=%b required 0 0 0 0 0",
                     count, overflow, underflow, busy, mem_wren);
         end
      end else if (p && n < SIZE) begin
         stk_q.push_back(d);
         total++;
         if (mem_wren !== 1'b1 || mem_address !== AW'(n) || mem_data !== d || count !== 6'(n + 1) || busy !== 1'b1) begin
            bad++;
            $display("FAIL push_issue: wren=%b addr=%0d data=%h count=%0d busy=%b required 1 %0d %h %0d 1",
                     mem_wren, mem_address, mem_data, count, busy, n, d, n + 1);
         end
         @(posedge clock); #1;
         total++;
         if (mem_wren !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL push_done: wren=%b busy=%b required 0 0", mem_wren, busy);
         end
      end else if (p) begin
         m_ovf = 1'b1;
         total++;
         if (mem_wren !== 1'b0 || busy !== 1'b0 || count !== 6'(SIZE)) begin
            bad++;
            $display("FAIL push_full: wren=%b busy=%b count=%0d required 0 0 %0d", mem_wren, busy, count, SIZE);
         end
      end else if (q && n > 0) begin
         exp_d = stk_q.pop_back();
         total++;
         if (count !== 6'(n - 1) || mem_address !== AW'(n - 1) || busy !== 1'b1 || mem_wren !== 1'b0) begin
            bad++;
            $display("FAIL pop_issue: count=%0d addr=%0d busy=%b wren=%b required %0d %0d 1 0",
                     count, mem_address, busy, mem_wren, n - 1, n - 1);
         end
         cyc = 0;
         while (cyc < 6 && dout_valid !== 1'b1) begin
            @(posedge clock); #1;
            cyc++;
         end
         total++;
         if (cyc !== 2 || dout !== exp_d) begin
            bad++;
            $display("FAIL pop_data: latency=%0d dout=%h required 2 %h", cyc, dout, exp_d);
         end
         m_dout = exp_d;
         @(posedge clock); #1;
         total++;
         if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== exp_d) begin
            bad++;
            $display("FAIL pop_done: valid=%b busy=%b dout=%h required 0 0 %h", dout_valid, busy, dout, exp_d);
         end
      end else if (q) begin
         m_unf = 1'b1;
         total++;
         if (busy !== 1'b0 || dout_valid !== 1'b0 || dout !== m_dout) begin
            bad++;
            $display("FAIL pop_empty: busy=%b valid=%b dout=%h required 0 0 %h", busy, dout_valid, dout, m_dout);
         end
      end
      total++;
      if (count !== 6'(stk_q.size()) || full !== (stk_q.size() == SIZE) || empty !== (stk_q.size() == 0) ||
          overflow !== m_ovf || underflow !== m_unf) begin
         bad++;
         $display("FAIL status: count=%0d full=%b empty=%b ovf=%b unf=%b required %0d %b %b %b %b",
                  count, full, empty, overflow, underflow, stk_q.size(), stk_q.size() == SIZE,
                  stk_q.size() == 0, m_ovf, m_unf);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || mem_wren !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: count=%0d empty=%b full=%b busy=%b wren=%b required 0 1 0 0 0",
                  count, empty, full, busy, mem_wren);
      end
      reset_n = 1'b1;
      @(posedge clock); #1;
      total++;
      if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || mem_wren !== 1'b0 || dout !== 8'h00 ||
          busy !== 1'b0 || dout_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || mem_address !== 5'd0) begin
         bad++;
         $display("FAIL reset_release: count=%0d empty=%b full=%b wren=%b dout=%h busy=%b valid=%b ovf=%b unf=%b addr=%0d",
                  count, empty, full, mem_wren, dout, busy, dout_valid, overflow, underflow, mem_address);
      end
      stk_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
   endtask

   task automatic test_push_pop_order();
      op_req(1'b0, 1'b1, 1'b0, 8'h02);
      op_req(1'b0, 1'b1, 1'b0, 8'h04);
      op_req(1'b0, 1'b1, 1'b0, 8'h06);
      repeat (3) op_req(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_fill_overflow();
      for (int k = 0; k < SIZE; k++) op_req(1'b0, 1'b1, 1'b0, 8'(2 * k));
      op_req(1'b0, 1'b1, 1'b0, 8'hEE);
      total++;
      if (overflow !== 1'b1 || count !== 6'd32 || full !== 1'b1) begin
         bad++;
         $display("FAIL overflow: ovf=%b count=%0d full=%b required 1 32 1", overflow, count, full);
      end
      op_req(1'b0, 1'b0, 1'b1, 8'h00);
      op_req(1'b0, 1'b1, 1'b0, 8'h77);
   endtask

   task automatic test_priority_flush();
      op_req(1'b1, 1'b1, 1'b1, 8'h33);
      op_req(1'b0, 1'b1, 1'b1, 8'h11);
      op_req(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_empty_busy();
      op_req(1'b0, 1'b0, 1'b1, 8'h00);
      push = 1'b1; din = 8'hAA;
      @(posedge clock); #1;
      push = 1'b0; pop = 1'b1;
      stk_q.push_back(8'hAA);
      @(posedge clock); #1;
      pop = 1'b0;
      total++;
      if (count !== 6'd1 || mem_wren !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
         bad++;
         $display("FAIL pop_while_busy: count=%0d wren=%b busy=%b valid=%b required 1 0 0 0",
                  count, mem_wren, busy, dout_valid);
      end
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (count !== 6'd1 || dout_valid !== 1'b0 || busy !== 1'b0 || underflow !== 1'b1) begin
         bad++;
         $display("FAIL busy_ignored: count=%0d valid=%b busy=%b unf=%b required 1 0 0 1",
                  count, dout_valid, busy, underflow);
      end
      op_req(1'b0, 1'b0, 1'b1, 8'h00);
      op_req(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_random();
      logic f;
      logic p;
      logic q;
      for (int i = 0; i < 120; i++) begin
         f = ($urandom_range(0, 24) == 0);
         p = ($urandom_range(0, 9) < 6);
         q = ($urandom_range(0, 1) == 1);
         op_req(f, p, q, 8'($urandom));
      end
   endtask

   task automatic test_reset_mid_pop();
      int pulses;
      op_req(1'b0, 1'b1, 1'b0, 8'h5A);
      pop = 1'b1;
      @(posedge clock); #1;
      pop = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_pop_busy: busy=%b required 1", busy);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (count !== 6'd0 || dout_valid !== 1'b0 || busy !== 1'b0 || mem_wren !== 1'b0 || dout !== 8'h00 ||
          mem_address !== 5'd0 || mem_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
         bad++;
         $display("FAIL mid_pop_reset: count=%0d valid=%b busy=%b wren=%b dout=%h addr=%0d data=%h ovf=%b unf=%b",
                  count, dout_valid, busy, mem_wren, dout, mem_address, mem_data, overflow, underflow);
      end
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      stk_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         if (dout_valid === 1'b1 || busy === 1'b1) pulses++;
      end
      total++;
      if (pulses !== 0 || count !== 6'd0 || empty !== 1'b1) begin
         bad++;
         $display("FAIL mid_pop_after: activity=%0d count=%0d empty=%b required 0 0 1", pulses, count, empty);
      end
   endtask

   initial begin
      test_reset();
      test_push_pop_order();
      test_fill_overflow();
      test_priority_flush();
      test_empty_busy();
      test_random();
      test_reset_mid_pop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
